// File: rtl/led_bank_arbiter.sv
// LED bank owner: selects between the Ibex GPO word, a hardware status view and a
// walking-one lamp test, switched by a debounced mode button (short press cycles, long press -> GPO).
module led_bank_arbiter #(
    parameter int unsigned LedWidth        = 16,
    parameter int unsigned DebounceCycles  = 65536,
    parameter int unsigned HoldCycles      = 50000000,
    parameter int unsigned HeartbeatCycles = 25000000,
    parameter int unsigned StretchCycles   = 2500000,
    parameter int unsigned WalkCycles      = 12500000
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_i,
    input  logic                mode_btn_i,
    input  logic [LedWidth-1:0] gpo_i,
    input  logic                uart_rx_i,
    input  logic                uart_tx_i,
    output logic [LedWidth-1:0] led_o,
    output logic [1:0]          mode_o
);

    localparam int unsigned DbW   = $clog2(DebounceCycles);
    localparam int unsigned HoldW = $clog2(HoldCycles);
    localparam int unsigned HbW   = $clog2(HeartbeatCycles);
    localparam int unsigned StW   = $clog2(StretchCycles + 1);
    localparam int unsigned WalkW = $clog2(WalkCycles);

    localparam logic [DbW-1:0]      DbMax    = DbW'(DebounceCycles - 1);
    localparam logic [HoldW-1:0]    HoldMax  = HoldW'(HoldCycles - 1);
    localparam logic [HbW-1:0]      HbMax    = HbW'(HeartbeatCycles - 1);
    localparam logic [StW-1:0]      StLoad   = StW'(StretchCycles);
    localparam logic [WalkW-1:0]    WalkMax  = WalkW'(WalkCycles - 1);
    localparam logic [LedWidth-1:0] WalkInit = LedWidth'(1);

    localparam logic [1:0] ModeGpo    = 2'd0;
    localparam logic [1:0] ModeStatus = 2'd1;
    localparam logic [1:0] ModeWalk   = 2'd2;

    typedef enum logic [1:0] {
        PressIdle = 2'd0,
        PressHeld = 2'd1,
        PressLong = 2'd2
    } press_state_e;

    logic                btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic                rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    logic                prev_rx_q, prev_rx_d, prev_tx_q, prev_tx_d;
    logic [DbW-1:0]      db_cnt_q, db_cnt_d;
    logic                db_q, db_d;
    logic                db_rise_c, db_fall_c;
    press_state_e        state_q, state_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [1:0]          mode_q, mode_d;
    logic [HbW-1:0]      hb_cnt_q, hb_cnt_d;
    logic                hb_q, hb_d;
    logic [StW-1:0]      rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic                rx_act_c, tx_act_c;
    logic [WalkW-1:0]    step_q, step_d;
    logic [LedWidth-1:0] walk_q, walk_d;
    logic [LedWidth-1:0] led_q, led_d;

    // State register for every flop in the block
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            prev_rx_q  <= 1'b1;
            prev_tx_q  <= 1'b1;
            db_cnt_q   <= '0;
            db_q       <= 1'b0;
            state_q    <= PressIdle;
            hold_q     <= '0;
            mode_q     <= ModeGpo;
            hb_cnt_q   <= '0;
            hb_q       <= 1'b0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            step_q     <= '0;
            walk_q     <= WalkInit;
            led_q      <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            prev_rx_q  <= prev_rx_d;
            prev_tx_q  <= prev_tx_d;
            db_cnt_q   <= db_cnt_d;
            db_q       <= db_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            mode_q     <= mode_d;
            hb_cnt_q   <= hb_cnt_d;
            hb_q       <= hb_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            step_q     <= step_d;
            walk_q     <= walk_d;
            led_q      <= led_d;
        end
    end

    // Two-flop synchronisers and edge-history flops
    always_comb begin
        btn_meta_d = mode_btn_i;
        btn_sync_d = btn_meta_q;
        rx_meta_d  = uart_rx_i;
        rx_sync_d  = rx_meta_q;
        prev_rx_d  = rx_sync_q;
        prev_tx_d  = uart_tx_i;
    end

    // Debounce: accept a new level after it has differed for DebounceCycles samples
    always_comb begin
        db_cnt_d = '0;
        db_d     = db_q;
        if (btn_sync_q != db_q) begin
            if (db_cnt_q == DbMax) begin
                db_d     = btn_sync_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    // Press events fire in the cycle the debounced value flips, so the FSM reacts without extra latency
    assign db_rise_c = db_d & ~db_q;
    assign db_fall_c = ~db_d & db_q;

    // Press FSM; long-press detection wins over a coincident release
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        case (state_q)
            PressIdle: begin
                if (db_rise_c) begin
                    state_d = PressHeld;
                    hold_d  = '0;
                end
            end
            PressHeld: begin
                if (hold_q == HoldMax) begin
                    state_d = PressLong;
                    mode_d  = ModeGpo;
                end else if (db_fall_c) begin
                    state_d = PressIdle;
                    mode_d  = (mode_q == ModeWalk) ? ModeGpo : mode_q + 2'd1;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            PressLong: begin
                if (db_fall_c) begin
                    state_d = PressIdle;
                end
            end
            default: state_d = PressIdle;
        endcase
    end

    // Free-running heartbeat
    always_comb begin
        hb_cnt_d = hb_cnt_q + HbW'(1);
        hb_d     = hb_q;
        if (hb_cnt_q == HbMax) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end
    end

    // Activity stretchers; a fresh falling edge always reloads, even on the last count
    always_comb begin
        rx_cnt_d = rx_cnt_q;
        tx_cnt_d = tx_cnt_q;
        if (prev_rx_q && !rx_sync_q) begin
            rx_cnt_d = StLoad;
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - StW'(1);
        end
        if (prev_tx_q && !uart_tx_i) begin
            tx_cnt_d = StLoad;
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - StW'(1);
        end
    end

    assign rx_act_c = (rx_cnt_q != '0);
    assign tx_act_c = (tx_cnt_q != '0);

    // Walking one: restarts from bit 0 on entry to walk mode, frozen otherwise
    always_comb begin
        walk_d = walk_q;
        step_d = step_q;
        if (mode_d == ModeWalk && mode_q != ModeWalk) begin
            walk_d = WalkInit;
            step_d = '0;
        end else if (mode_q == ModeWalk) begin
            if (step_q == WalkMax) begin
                step_d = '0;
                walk_d = {walk_q[LedWidth-2:0], walk_q[LedWidth-1]};
            end else begin
                step_d = step_q + WalkW'(1);
            end
        end
    end

    // Registered output mux
    always_comb begin
        led_d = '0;
        case (mode_q)
            ModeGpo:    led_d = gpo_i;
            ModeStatus: led_d[2:0] = {tx_act_c, rx_act_c, hb_q};
            ModeWalk:   led_d = walk_q;
            default:    led_d = '0;
        endcase
    end

    assign led_o  = led_q;
    assign mode_o = mode_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter: an edge-indexed behavioural model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_led_bank_arbiter;

    localparam int TLW   = 16;
    localparam int TDB   = 4;
    localparam int THOLD = 20;
    localparam int THB   = 8;
    localparam int TST   = 5;
    localparam int TWK   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            btn = 1'b0;
    logic            rx  = 1'b1;
    logic            tx  = 1'b1;
    logic [TLW-1:0]  gpo = 16'hA5A5;
    logic [TLW-1:0]  led;
    logic [1:0]      mode;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    led_bank_arbiter #(
        .LedWidth(TLW), .DebounceCycles(TDB), .HoldCycles(THOLD),
        .HeartbeatCycles(THB), .StretchCycles(TST), .WalkCycles(TWK)
    ) dut (
        .clk_sys_i(clk), .rst_sys_i(rst), .mode_btn_i(btn), .gpo_i(gpo),
        .uart_rx_i(rx), .uart_tx_i(tx), .led_o(led), .mode_o(mode)
    );

    // Model state; time is expressed as the number of clock edges since reset
    int       m_n = 0, m_tx_fall = -100, m_rx_fall = -100, m_run = 0;
    int       m_press_edge = 0, m_entry = 0, m_pst = 0, m_mode = 0;
    logic     m_prev_tx = 1'b1, m_prev_rx = 1'b1, m_rx_s1 = 1'b1, m_rx_s2 = 1'b1;
    logic     m_btn_s1 = 1'b0, m_btn_s2 = 1'b0, m_db = 1'b0;
    logic [TLW-1:0] m_led = '0;

    task automatic check(input string name, input logic [TLW-1:0] act, input logic [TLW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_tx_fall = -100; m_rx_fall = -100; m_run = 0;
        m_press_edge = 0; m_entry = 0; m_pst = 0; m_mode = 0;
        m_prev_tx = 1'b1; m_prev_rx = 1'b1; m_rx_s1 = 1'b1; m_rx_s2 = 1'b1;
        m_btn_s1 = 1'b0; m_btn_s2 = 1'b0; m_db = 1'b0; m_led = '0;
    endtask

    task automatic model_step();
        int k, prev_mode;
        logic [TLW-1:0] one;
        logic hb, txa, rxa, syn;
        bit rise, fall;
        one = 16'h0001;
        hb  = ((m_n / THB) % 2) == 1;
        txa = (m_n - m_tx_fall) < TST;
        rxa = (m_n - m_rx_fall) < TST;
        case (m_mode)
            0:       m_led = gpo;
            1:       m_led = {13'd0, txa, rxa, hb};
            2:       m_led = one << (((m_n - m_entry) / TWK) % TLW);
            default: m_led = '0;
        endcase
        k = m_n + 1;
        if (m_prev_tx && !tx) m_tx_fall = k;
        m_prev_tx = tx;
        if (m_prev_rx && !m_rx_s2) m_rx_fall = k;
        m_prev_rx = m_rx_s2;
        m_rx_s2 = m_rx_s1;
        m_rx_s1 = rx;
        syn = m_btn_s2;
        m_btn_s2 = m_btn_s1;
        m_btn_s1 = btn;
        rise = 1'b0;
        fall = 1'b0;
        if (syn != m_db) begin
            m_run++;
            if (m_run == TDB) begin
                m_db = syn;
                m_run = 0;
                rise = syn;
                fall = !syn;
            end
        end else begin
            m_run = 0;
        end
        prev_mode = m_mode;
        case (m_pst)
            0: if (rise) begin m_pst = 1; m_press_edge = k; end
            1: begin
                if (k - m_press_edge == THOLD) begin
                    m_mode = 0;
                    m_pst = 2;
                end else if (fall) begin
                    m_mode = (m_mode + 1) % 3;
                    m_pst = 0;
                end
            end
            default: if (fall) m_pst = 0;
        endcase
        if (m_mode == 2 && prev_mode != 2) m_entry = k;
        m_n = k;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    // Continuous compare against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("led_vs_model", led, m_led);
            check("mode_vs_model", {14'd0, mode}, 16'(m_mode));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic short_press();
        btn = 1'b1;
        step(10);
        btn = 1'b0;
        step(6);
    endtask

    initial begin
        // Reset held, then released with GPO word present
        step(3);
        check("rst_led", led, 16'h0000);
        check("rst_mode", {14'd0, mode}, 16'h0000);
        chk_en = 1'b1;
        rst = 1'b0;
        step(1);
        check("first_gpo", led, 16'hA5A5);
        gpo = 16'h3C3C;
        step(1);
        check("gpo_follow", led, 16'h3C3C);

        // Glitch shorter than debounce is ignored
        btn = 1'b1;
        step(3);
        btn = 1'b0;
        step(8);
        check("glitch_mode", {14'd0, mode}, 16'h0000);

        // Clean press: mode advances 4 edges after the synced fall
        btn = 1'b1;
        step(10);
        btn = 1'b0;
        step(5);
        check("short_pre", {14'd0, mode}, 16'h0000);
        step(1);
        check("short_mode1", {14'd0, mode}, 16'h0001);

        // Status view: rx activity, tx stretch and retrigger
        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(10);
        tx = 1'b0;
        step(1);
        tx = 1'b1;
        check("tx_lat", {15'd0, led[2]}, 16'h0000);
        step(1);
        check("tx_on", {15'd0, led[2]}, 16'h0001);
        check("status_hi", {3'd0, led[15:3]}, 16'h0000);
        step(1);
        tx = 1'b0;
        step(1);
        tx = 1'b1;
        step(5);
        check("tx_retrig_on", {15'd0, led[2]}, 16'h0001);
        step(1);
        check("tx_retrig_off", {15'd0, led[2]}, 16'h0000);

        // Walk mode: one-hot steps every WalkCycles, wrapping after bit 15
        short_press();
        check("walk_mode", {14'd0, mode}, 16'h0002);
        step(1);
        check("walk_0", led, 16'h0001);
        for (int i = 1; i <= 16; i++) begin
            logic [TLW-1:0] exp_w;
            exp_w = 16'h0001;
            exp_w = exp_w << (i % 16);
            step(3);
            check("walk_step", led, exp_w);
        end

        // Long press from walk mode forces GPO; release leaves it there
        btn = 1'b1;
        step(25);
        check("long_pre", {14'd0, mode}, 16'h0002);
        step(1);
        check("long_mode0", {14'd0, mode}, 16'h0000);
        step(14);
        btn = 1'b0;
        step(10);
        check("long_release", {14'd0, mode}, 16'h0000);

        // Reset mid-walk with the button held
        short_press();
        short_press();
        check("walk_again", {14'd0, mode}, 16'h0002);
        btn = 1'b1;
        step(8);
        #2;
        rst = 1'b1;
        #1;
        check("async_led", led, 16'h0000);
        check("async_mode", {14'd0, mode}, 16'h0000);
        step(2);
        rst = 1'b0;
        step(8);
        check("no_carry", {14'd0, mode}, 16'h0000);
        btn = 1'b0;
        step(5);
        check("new_press_pre", {14'd0, mode}, 16'h0000);
        step(1);
        check("new_press", {14'd0, mode}, 16'h0001);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
